// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data RAM,
// with byte/halfword stores done as read-merge-write. Define DATA_MEM_ARBITER_SIGNEXT_EN to sign-extend LB/LH.
module data_mem_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic [5:0]        p0_op,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic [5:0]        p1_op,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [31:0]       p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;

    typedef enum logic [2:0] {IDLE, RD, MRG, WR, RSP} state_t;

    state_t              state, next_state;
    logic                gnt, last_gnt;
    logic [5:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;

    logic                any_req, sel, req_err;
    logic [5:0]          req_op;
    logic [31:0]         req_addr, req_wdata;
    logic                ext8, ext16;
    logic [31:0]         rsp_rdata;

    assign any_req = p0_req | p1_req;

    // Round-robin pick: on a tie the port not granted last time wins.
    always_comb begin
        sel = 1'b0;
        if (p0_req && p1_req)
            sel = ~last_gnt;
        else if (p1_req)
            sel = 1'b1;
        req_op    = sel ? p1_op    : p0_op;
        req_addr  = sel ? p1_addr  : p0_addr;
        req_wdata = sel ? p1_wdata : p0_wdata;
        req_err   = (req_addr[31:ADDR_W] != '0);
        case (req_op)
            OP_LW, OP_LB, OP_LH, OP_SW, OP_SB, OP_SH: ;
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && any_req) begin
                gnt      <= sel;
                last_gnt <= sel;
                op_q     <= req_op;
                addr_q   <= req_addr[ADDR_W-1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (req_err)
                        next_state = RSP;
                    else if (req_op == OP_SW)
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD:      next_state = (op_q == OP_SB || op_q == OP_SH) ? MRG : RSP;
            MRG:     next_state = RSP;
            WR:      next_state = RSP;
            RSP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef DATA_MEM_ARBITER_SIGNEXT_EN
    assign ext8  = mem_rdata[7];
    assign ext16 = mem_rdata[15];
`else
    assign ext8  = 1'b0;
    assign ext16 = 1'b0;
`endif

    always_comb begin
        rsp_rdata = '0;
        if (!err_q) begin
            case (op_q)
                OP_LW:   rsp_rdata = mem_rdata;
                OP_LB:   rsp_rdata = {{24{ext8}}, mem_rdata[7:0]};
                OP_LH:   rsp_rdata = {{16{ext16}}, mem_rdata[15:0]};
                default: rsp_rdata = '0;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        p0_ack    = 1'b0;
        p0_err    = 1'b0;
        p0_rdata  = '0;
        p1_ack    = 1'b0;
        p1_err    = 1'b0;
        p1_rdata  = '0;
        busy      = (state != IDLE);
        case (state)
            RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
            end
            MRG: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = (op_q == OP_SB) ? {mem_rdata[31:8], wdata_q[7:0]}
                                            : {mem_rdata[31:16], wdata_q[15:0]};
            end
            WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RSP: begin
                if (gnt) begin
                    p1_ack   = 1'b1;
                    p1_err   = err_q;
                    p1_rdata = rsp_rdata;
                end else begin
                    p0_ack   = 1'b1;
                    p0_err   = err_q;
                    p0_rdata = rsp_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter: a word-array reference model
// predicts grant order, latency, load data, error flag and final memory contents.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] LB = 6'b100000;
    localparam logic [5:0] LH = 6'b100001;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] SB = 6'b101000;
    localparam logic [5:0] SH = 6'b101001;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              p0_req, p1_req;
    logic [5:0]        p0_op, p1_op;
    logic [31:0]       p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic              p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_en, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    logic [5:0]  r_op    [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    bit          pend    [2];
    bit          req_on  [2];
    int          last_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port synchronous RAM the arbiter drives.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit isLegal(input logic [5:0] op);
        return op == LW || op == LB || op == LH || op == SW || op == SB || op == SH;
    endfunction

    function automatic logic [31:0] loadValue(input logic [5:0] op, input logic [31:0] w);
        logic [31:0] v;
        v = 32'h0;
        if (op == LW) v = w;
        if (op == LB) begin
            v = w & 32'hFF;
`ifdef DATA_MEM_ARBITER_SIGNEXT_EN
            if (w[7]) v = v | 32'hFFFF_FF00;
`endif
        end
        if (op == LH) begin
            v = w & 32'hFFFF;
`ifdef DATA_MEM_ARBITER_SIGNEXT_EN
            if (w[15]) v = v | 32'hFFFF_0000;
`endif
        end
        return v;
    endfunction

    function automatic logic portAck(input int p);
        return (p == 1) ? p1_ack : p0_ack;
    endfunction
    function automatic logic portErr(input int p);
        return (p == 1) ? p1_err : p0_err;
    endfunction
    function automatic logic [31:0] portRdata(input int p);
        return (p == 1) ? p1_rdata : p0_rdata;
    endfunction

    task automatic drivePins();
        p0_req = req_on[0]; p0_op = r_op[0]; p0_addr = r_addr[0]; p0_wdata = r_wdata[0];
        p1_req = req_on[1]; p1_op = r_op[1]; p1_addr = r_addr[1]; p1_wdata = r_wdata[1];
    endtask

    task automatic postReq(input int p, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata);
        r_op[p] = op; r_addr[p] = addr; r_wdata[p] = wdata;
        pend[p] = 1'b1; req_on[p] = 1'b1;
        drivePins();
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        ram[a] = v;
        ref_mem[a] = v;
    endtask

    // Serve every posted request, predicting each transaction from the model.
    // Called at a negedge with the DUT idle.
    task automatic applyStimulus(input bit may_drop);
        int g, lat, a;
        bit e;
        logic [31:0] word, er, nw;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) g = 1 - last_m;
            else g = pend[0] ? 0 : 1;
            e = !isLegal(r_op[g]) || (r_addr[g] >= DEPTH);
            a = int'(r_addr[g] % DEPTH);
            word = ref_mem[a];
            lat = e ? 1 : ((r_op[g] == SB || r_op[g] == SH) ? 3 : 2);
            er = e ? 32'h0 : loadValue(r_op[g], word);
            if (!e) begin
                nw = word;
                if (r_op[g] == SW) nw = r_wdata[g];
                if (r_op[g] == SB) nw = (word & 32'hFFFF_FF00) | (r_wdata[g] & 32'hFF);
                if (r_op[g] == SH) nw = (word & 32'hFFFF_0000) | (r_wdata[g] & 32'hFFFF);
                ref_mem[a] = nw;
            end
            last_m = g;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                checkOutput("busy", 32'(busy), 32'd1);
                checkOutput("ack_granted", 32'(portAck(g)), 32'(k == lat));
                checkOutput("ack_other", 32'(portAck(1 - g)), 32'd0);
                checkOutput("mem_en", 32'(mem_en), 32'(!e && k < lat));
                if (k == lat) begin
                    checkOutput("err", 32'(portErr(g)), 32'(e));
                    checkOutput("rdata", portRdata(g), er);
                    checkOutput("rdata_other", portRdata(1 - g), 32'h0);
                end
                if (may_drop && k == 1 && lat > 1 && $urandom_range(0, 1) == 1) begin
                    req_on[g] = 1'b0;
                    drivePins();
                end
            end
            req_on[g] = 1'b0;
            pend[g] = 1'b0;
            drivePins();
            @(negedge clk);
            checkOutput("idle_gap", 32'(busy), 32'd0);
        end
    endtask

    function automatic logic [5:0] randOp();
        logic [5:0] ops [6];
        ops = '{LW, LB, LH, SW, SB, SH};
        if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 31));
        return ops[$urandom_range(0, 5)];
    endfunction

    function automatic logic [31:0] randAddr();
        if ($urandom_range(0, 7) == 0) return 32'($urandom_range(32, 200));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            r_op[i] = '0; r_addr[i] = '0; r_wdata[i] = '0; pend[i] = 0; req_on[i] = 0;
        end
        drivePins();
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        last_m = 1;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
        checkOutput("rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
        checkOutput("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        preload(3, 32'hAABB_CCDD);
        postReq(0, LW, 32'd3, 32'h0);
        applyStimulus(1'b0);

        preload(5, 32'h1122_3344);
        postReq(1, SB, 32'd5, 32'h0000_00EE);
        applyStimulus(1'b0);
        checkOutput("sb_mem5", ram[5], 32'h1122_33EE);

        preload(2, 32'h0000_8081);
        postReq(0, LB, 32'd2, 32'h0);
        applyStimulus(1'b0);
        postReq(1, LH, 32'd2, 32'h0);
        applyStimulus(1'b0);

        postReq(0, 6'b000000, 32'd1, 32'h0);
        applyStimulus(1'b0);
        postReq(0, LW, 32'h40, 32'h0);
        applyStimulus(1'b0);

        for (int r = 0; r < 3; r++) begin
            postReq(0, randOp(), randAddr(), $urandom);
            postReq(1, randOp(), randAddr(), $urandom);
            applyStimulus(1'b0);
        end

        for (int r = 0; r < 60; r++) begin
            int who;
            who = $urandom_range(1, 3);
            if (who[0]) postReq(0, randOp(), randAddr(), $urandom);
            if (who[1]) postReq(1, randOp(), randAddr(), $urandom);
            applyStimulus(1'b1);
        end

        // Reset in the middle of a halfword merge must abandon the store.
        postReq(0, SH, 32'd7, 32'h0000_BEEF);
        @(negedge clk);
        checkOutput("sh_rd_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        checkOutput("sh_mrg_we", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_we", 32'(mem_we), 32'd0);
        checkOutput("abort_ack", 32'(p0_ack), 32'd0);
        pend[0] = 0; req_on[0] = 0; drivePins();
        last_m = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        postReq(0, LW, 32'd7, 32'h0);
        postReq(1, LW, 32'd7, 32'h0);
        applyStimulus(1'b0);

        for (int i = 0; i < DEPTH; i++) checkOutput("final_mem", ram[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
